condicionador_botoes: RTL and testbench
=======================================

# condicionador_botoes

Conditions the eight raw push-button inputs and produces the one-cycle toggle pulses consumed on `botoes` by the LED-matrix controller. Each button passes through a two-flop synchronizer and a per-button debounce state machine. Exactly one pulse is issued per confirmed press, with none on release or bounce. The block also keeps a saturating move counter that the control unit reads to score the level.

## Interface
- `DEBOUNCE_CICLOS`, default 500000: consecutive stable cycles required to confirm a press or release (10 ms at 50 MHz); must be ≥ 1.
- `ATIVO_BAIXO`, default 1: 1 means a raw button reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `botoes_brutos` in 8: raw asynchronous button levels from the pins.
- `habilitar` in 1: 1 allows pulses out; 0 masks them (the UC drives it low between levels).
- `limpar_jogadas` in 1: synchronous clear of `jogadas`.
- `botoes_pulso` out 8: one-cycle pulse per confirmed press; feeds the matrix `botoes` input.
- `jogadas` out 10: count of pulses emitted, saturating at 1023.

## Operation
- **Input normalisation:** the raw input is inverted when `ATIVO_BAIXO=1`. Internally, 1 always means pressed.
- **Synchronizer:** two flops per bit; the output of the second flop is called `s`.
- **Per-button FSM:** four states, with counter `cnt` of width `$clog2(DEBOUNCE_CICLOS)` (minimum 1 bit).
  - `SOLTO`: if `s=1`, go to `CONFIRMA_PRESSAO` with `cnt←0`.
  - `CONFIRMA_PRESSAO`:
    - If `s=0`, return to `SOLTO` with `cnt←0`.
    - Else if `cnt==DEBOUNCE_CICLOS-1`, go to `PRESSIONADO` and fire the pulse.
    - Else `cnt++`.
  - `PRESSIONADO`: if `s=0`, go to `CONFIRMA_SOLTURA` with `cnt←0`.
  - `CONFIRMA_SOLTURA`:
    - If `s=1`, return to `PRESSIONADO` with no new pulse.
    - Else if `cnt==DEBOUNCE_CICLOS-1`, go to `SOLTO`.
    - Else `cnt++`.
- **Pulse:** `botoes_pulso[k]` is registered. It is 1 for exactly the cycle after the `CONFIRMA_PRESSAO→PRESSIONADO` transition, and only if `habilitar=1` on the transition edge.
- **Masked presses:** a press confirmed while `habilitar=0` is lost. It does not fire later when `habilitar` rises, because the FSM is already in `PRESSIONADO`.
- **Simultaneous presses:** buttons are independent, so any subset may pulse in the same cycle.
- **Move counter:** `jogadas` adds the popcount of the pulses registered that cycle and saturates at 1023. For example, 1022 plus 3 pulses gives 1023.
- **Clear priority:** `limpar_jogadas=1` forces `jogadas←0`. Pulses registered on that same edge are not counted.
- **Reset** (`rst=1`), applied on the next edge and taking priority over everything:
  - all FSMs go to `SOLTO`, with `cnt=0`;
  - sync flops go to the released level (internal 0);
  - `botoes_pulso=0` and `jogadas=0`.
- **Button held through reset:** it counts as a new press once `rst` falls and yields one pulse after the full latency.

## Timing
- **Press latency:** raw level stable from rising edge E0 → pulse visible after edge E0+DEBOUNCE_CICLOS+2. That is the (DEBOUNCE_CICLOS+3)th edge counting E0, broken down as 2 synchronizer edges, 1 `SOLTO` exit edge and DEBOUNCE_CICLOS confirm edges.
- **Release:** confirmed after the same number of edges; it has no output effect.
- **Pulse width:** always exactly 1 cycle. A button never pulses again until it has passed through `SOLTO`.
- **Bounce:** a level that is stable for fewer than DEBOUNCE_CICLOS+1 consecutive synchronized samples in a confirm state produces no pulse.
- **Counter latency:** `jogadas` reflects a pulse one cycle after `botoes_pulso` is high.
- **Output reset values:** `botoes_pulso=8'h00` and `jogadas=10'd0`.

## Structure
- **Shared package `pkg_botoes`:**
  - 2-bit state encoding localparams `SOLTO=0`, `CONFIRMA_PRESSAO=1`, `PRESSIONADO=2`, `CONFIRMA_SOLTURA=3`;
  - `NUM_BOTOES=8`;
  - `JOGADAS_MAX=1023`.
- **Sub-module `debounce_botao`:** one button, containing the synchronizer, FSM and counter, and outputting a one-cycle `pressionou`. It is instantiated 8× via generate. Masking, pulse registering and popcount/saturation live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CICLOS=4` and `ATIVO_BAIXO=1`.
1. **Clean press:** `botoes_brutos[2]` 1→0 held 20 cycles → `botoes_pulso=8'h04` for exactly 1 cycle, 7 edges after the change; `jogadas=1`. No pulse on release.
2. **Bounce:** bit 0 alternates every 2 cycles for 12 cycles, then is held low → exactly one pulse, 7 edges after the final stable low. Release bounce produces no pulse.
3. **Simultaneous press with saturation:** preload `jogadas=1022` via 1022 presses (or a forced value), then press bits 1, 4 and 7 together → `botoes_pulso=8'h92` for one cycle; `jogadas=1023`.
4. **Masking:** with `habilitar=0`, press bit 3 and hold it; raise `habilitar` → no pulse and `jogadas` unchanged. Release and press again → one pulse.
5. **Clear vs pulse:** `limpar_jogadas=1` on the same edge a pulse registers → `jogadas=0` next cycle; the pulse is still output.
6. **Reset mid-confirm:** `rst` asserted during `CONFIRMA_PRESSAO` with bit 5 held → outputs 0. After `rst` falls, one pulse on bit 5 after 7 edges.

Source files
------------

// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM states,
// button count, move-counter limit and a popcount helper.
package pkg_botoes;

   localparam int NUM_BOTOES  = 8;
   localparam int JOGADAS_W   = 10;
   localparam int JOGADAS_MAX = 1023;

   typedef enum logic [1:0] {
      SOLTO            = 2'd0,
      CONFIRMA_PRESSAO = 2'd1,
      PRESSIONADO      = 2'd2,
      CONFIRMA_SOLTURA = 2'd3
   } estado_t;

   function automatic logic [3:0] contar_uns(input logic [NUM_BOTOES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NUM_BOTOES; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/condicionador_botoes_debounce.sv
// One button: two-flop synchronizer plus a four-state debounce FSM that
// raises pressionou for the single cycle on which a press is confirmed.
module debounce_botao
   import pkg_botoes::*;
#(
   parameter int DEBOUNCE_CICLOS = 500000,
   parameter int ATIVO_BAIXO     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic bruto,
   output logic pressionou
);

   localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

   logic          sync1_q, sync1_d;
   logic          s_q, s_d;
   estado_t       estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Normalise polarity before synchronizing so 1 always means pressed.
   always_comb begin
      sync1_d = (ATIVO_BAIXO != 0) ? ~bruto : bruto;
      s_d     = sync1_q;
   end

   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      pressionou = 1'b0;
      unique case (estado_q)
         SOLTO: begin
            if (s_q) begin
               estado_d = CONFIRMA_PRESSAO;
               cnt_d    = '0;
            end
         end
         CONFIRMA_PRESSAO: begin
            if (!s_q) begin
               estado_d = SOLTO;
               cnt_d    = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d   = PRESSIONADO;
               pressionou = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSIONADO: begin
            if (!s_q) begin
               estado_d = CONFIRMA_SOLTURA;
               cnt_d    = '0;
            end
         end
         CONFIRMA_SOLTURA: begin
            if (s_q) begin
               estado_d = PRESSIONADO;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = SOLTO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         s_q      <= 1'b0;
         estado_q <= SOLTO;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         s_q      <= s_d;
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/condicionador_botoes.sv
// Eight debounced buttons producing masked one-cycle toggle pulses, plus a
// saturating count of emitted pulses with a synchronous clear.
module condicionador_botoes
   import pkg_botoes::*;
#(
   parameter int DEBOUNCE_CICLOS = 500000,
   parameter int ATIVO_BAIXO     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_BOTOES-1:0] botoes_brutos,
   input  logic                  habilitar,
   input  logic                  limpar_jogadas,
   output logic [NUM_BOTOES-1:0] botoes_pulso,
   output logic [JOGADAS_W-1:0]  jogadas
);

   localparam logic [JOGADAS_W:0] LIMITE = (JOGADAS_W + 1)'(JOGADAS_MAX);

   logic [NUM_BOTOES-1:0] pressionou;
   logic [NUM_BOTOES-1:0] pulso_q, pulso_d;
   logic [JOGADAS_W-1:0]  jogadas_q, jogadas_d;
   logic [JOGADAS_W:0]    soma;

   generate
      for (genvar gi = 0; gi < NUM_BOTOES; gi++) begin : g_botao
         debounce_botao #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .ATIVO_BAIXO    (ATIVO_BAIXO)
         ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .bruto     (botoes_brutos[gi]),
            .pressionou(pressionou[gi])
         );
      end
   endgenerate

   // A press confirmed while masked is dropped for good; the FSM has moved on.
   always_comb begin
      pulso_d = pressionou & {NUM_BOTOES{habilitar}};
      soma    = {1'b0, jogadas_q} + (JOGADAS_W + 1)'(contar_uns(pulso_q));
      if (limpar_jogadas) begin
         jogadas_d = '0;
      end else if (soma > LIMITE) begin
         jogadas_d = LIMITE[JOGADAS_W-1:0];
      end else begin
         jogadas_d = soma[JOGADAS_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pulso_q   <= '0;
         jogadas_q <= '0;
      end else begin
         pulso_q   <= pulso_d;
         jogadas_q <= jogadas_d;
      end
   end

   assign botoes_pulso = pulso_q;
   assign jogadas      = jogadas_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboarded bench: a run-length reference model predicts pulses and the
// move count every cycle; directed scenarios are followed by random stimulus.
module tb_condicionador_botoes;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] botoes_brutos = 8'hFF;
   logic       habilitar = 1'b1;
   logic       limpar_jogadas = 1'b0;
   logic [7:0] botoes_pulso;
   logic [9:0] jogadas;

   bit [7:0] press = 8'h00;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] p;
      logic [9:0] j;
   } esperado_t;

   esperado_t fila[$];

   always #5 clk = ~clk;

   condicionador_botoes #(
      .DEBOUNCE_CICLOS(D),
      .ATIVO_BAIXO    (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .botoes_brutos (botoes_brutos),
      .habilitar     (habilitar),
      .limpar_jogadas(limpar_jogadas),
      .botoes_pulso  (botoes_pulso),
      .jogadas       (jogadas)
   );

   // Reference model: a button flips its confirmed level after D+1 consecutive
   // synchronized samples that disagree with it; a flip to pressed pulses.
   bit [7:0] m_p1, m_p2, m_conf, m_pulso;
   int       m_run[8];
   int       m_jog;

   always @(posedge clk) begin
      bit [7:0]  s;
      bit [7:0]  novo;
      esperado_t e;
      novo = 8'h00;
      if (rst) begin
         m_p1 = 8'h00;
         m_p2 = 8'h00;
         m_conf = 8'h00;
         for (int k = 0; k < 8; k++) m_run[k] = 0;
         m_jog = 0;
      end else begin
         s    = m_p2;
         m_p2 = m_p1;
         m_p1 = ~botoes_brutos;
         for (int k = 0; k < 8; k++) begin
            if (s[k] != m_conf[k]) begin
               m_run[k]++;
               if (m_run[k] == D + 1) begin
                  m_conf[k] = s[k];
                  m_run[k] = 0;
                  if (s[k] && habilitar) novo[k] = 1'b1;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         if (limpar_jogadas) m_jog = 0;
         else begin
            m_jog = m_jog + $countones(m_pulso);
            if (m_jog > 1023) m_jog = 1023;
         end
      end
      m_pulso = novo;
      e.p = m_pulso;
      e.j = 10'(m_jog);
      fila.push_back(e);
   end

   // Monitor: compares every presented output cycle against the scoreboard.
   always @(negedge clk) begin
      esperado_t e;
      if (fila.size() > 0) begin
         e = fila.pop_front();
         vectors++;
         if (botoes_pulso !== e.p || jogadas !== e.j) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t: pulso=%02h jogadas=%0d, required pulso=%02h jogadas=%0d",
                     $time, botoes_pulso, jogadas, e.p, e.j);
         end
         if (botoes_pulso != 8'h00)
            $display("t=%0t pulse botoes_pulso=%02h jogadas=%0d", $time, botoes_pulso, jogadas);
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pressionar(input bit [7:0] m);
      press = press | m;
      botoes_brutos = ~press;
   endtask

   task automatic soltar(input bit [7:0] m);
      press = press & ~m;
      botoes_brutos = ~press;
   endtask

   task automatic checar(input string nome, input logic [9:0] got, input logic [9:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", nome, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      habilitar = 1'b1;
      ciclos(3);
      checar("reset_pulso", {2'b00, botoes_pulso}, 10'h000);
      checar("reset_jogadas", jogadas, 10'd0);
      rst = 1'b0;
      ciclos(5);

      // Clean press on bit 2
      pressionar(8'h04);
      ciclos(6);
      checar("clean_before", {2'b00, botoes_pulso}, 10'h000);
      ciclos(1);
      checar("clean_pulse", {2'b00, botoes_pulso}, 10'h004);
      ciclos(1);
      checar("clean_width", {2'b00, botoes_pulso}, 10'h000);
      ciclos(1);
      checar("clean_jogadas", jogadas, 10'd1);
      ciclos(11);
      soltar(8'h04);
      ciclos(20);
      checar("clean_release", jogadas, 10'd1);

      // Bounce on bit 0
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) pressionar(8'h01); else soltar(8'h01);
         ciclos(2);
      end
      pressionar(8'h01);
      ciclos(6);
      checar("bounce_before", {2'b00, botoes_pulso}, 10'h000);
      ciclos(1);
      checar("bounce_pulse", {2'b00, botoes_pulso}, 10'h001);
      ciclos(15);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) soltar(8'h01); else pressionar(8'h01);
         ciclos(2);
      end
      soltar(8'h01);
      ciclos(20);
      checar("bounce_jogadas", jogadas, 10'd2);

      // Masked press on bit 3
      habilitar = 1'b0;
      pressionar(8'h08);
      ciclos(20);
      habilitar = 1'b1;
      ciclos(10);
      checar("mask_jogadas", jogadas, 10'd2);
      soltar(8'h08);
      ciclos(20);
      pressionar(8'h08);
      ciclos(20);
      checar("mask_repress", jogadas, 10'd3);
      soltar(8'h08);
      ciclos(20);

      // Clear on the edge that would count a pulse
      pressionar(8'h40);
      ciclos(7);
      checar("clear_pulse", {2'b00, botoes_pulso}, 10'h040);
      limpar_jogadas = 1'b1;
      ciclos(1);
      limpar_jogadas = 1'b0;
      checar("clear_jogadas", jogadas, 10'd0);
      ciclos(5);
      checar("clear_hold", jogadas, 10'd0);
      soltar(8'h40);
      ciclos(20);

      // Preload to 1022, then simultaneous press saturating the counter
      for (int r = 0; r < 127; r++) begin
         pressionar(8'hFF);
         ciclos(12);
         soltar(8'hFF);
         ciclos(12);
      end
      pressionar(8'h3F);
      ciclos(12);
      soltar(8'h3F);
      ciclos(12);
      checar("preload", jogadas, 10'd1022);
      pressionar(8'h92);
      ciclos(7);
      checar("simul_pulse", {2'b00, botoes_pulso}, 10'h092);
      ciclos(2);
      checar("saturate", jogadas, 10'd1023);
      soltar(8'h92);
      ciclos(12);
      pressionar(8'h01);
      ciclos(12);
      soltar(8'h01);
      ciclos(12);
      checar("saturate_hold", jogadas, 10'd1023);

      // Reset while bit 5 is mid-confirm
      pressionar(8'h20);
      ciclos(4);
      rst = 1'b1;
      ciclos(2);
      checar("rst_pulso", {2'b00, botoes_pulso}, 10'h000);
      checar("rst_jogadas", jogadas, 10'd0);
      rst = 1'b0;
      ciclos(6);
      checar("rst_before", {2'b00, botoes_pulso}, 10'h000);
      ciclos(1);
      checar("rst_pulse", {2'b00, botoes_pulso}, 10'h020);
      soltar(8'h20);
      ciclos(20);

      // Random traffic against the scoreboard
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 9) == 0) press[k] = ~press[k];
         end
         botoes_brutos = ~press;
         if ($urandom_range(0, 49) == 0) habilitar = ~habilitar;
         limpar_jogadas = ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 999) == 0);
         ciclos(1);
      end
      rst = 1'b0;
      limpar_jogadas = 1'b0;
      habilitar = 1'b1;
      soltar(8'hFF);
      ciclos(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
